// File: rtl/monitor_fim_de_jogo.sv
// End-of-game monitor for the battleship attack phase: counts shots, detects victory or defeat,
// and drives the LED-matrix columns with a blinking end-of-game animation.
module monitor_fim_de_jogo #(
   parameter int PISCA_TICKS = 4,
   parameter int MAX_TIROS   = 99
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       tick,
   input  logic       confirmar,
   input  logic [6:0] mapa0,
   input  logic [6:0] mapa1,
   input  logic [6:0] mapa2,
   input  logic [6:0] mapa3,
   input  logic [6:0] mapa4,
   input  logic [6:0] acerto0,
   input  logic [6:0] acerto1,
   input  logic [6:0] acerto2,
   input  logic [6:0] acerto3,
   input  logic [6:0] acerto4,
   input  logic [2:0] vida,
   output logic [6:0] matriz0,
   output logic [6:0] matriz1,
   output logic [6:0] matriz2,
   output logic [6:0] matriz3,
   output logic [6:0] matriz4,
   output logic [1:0] estado,
   output logic [6:0] tiros,
   output logic       fim
);

   localparam int CNT_W = (PISCA_TICKS > 1) ? $clog2(PISCA_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(PISCA_TICKS - 1);
   localparam logic [6:0] TIROS_MAX = 7'(MAX_TIROS);

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      JOGANDO = 2'b01,
      VITORIA = 2'b10,
      DERROTA = 2'b11
   } estado_t;

   estado_t          st, st_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             fase, fase_next;
   logic [6:0]       tiros_next;
   logic [34:0]      mapa_v, acerto_v, matriz_v, matriz_next;
   logic             vitoria, derrota;

   assign mapa_v   = {mapa4, mapa3, mapa2, mapa1, mapa0};
   assign acerto_v = {acerto4, acerto3, acerto2, acerto1, acerto0};

   // An empty map must never count as a win.
   assign vitoria = (|mapa_v) && ((mapa_v & ~acerto_v) == '0);
   assign derrota = (vida == 3'd0);

   always_comb begin
      st_next    = st;
      cnt_next   = cnt;
      fase_next  = fase;
      tiros_next = tiros;
      if (!enable) begin
         st_next = OCIOSO;
      end else begin
         unique case (st)
            OCIOSO: begin
               st_next    = JOGANDO;
               tiros_next = '0;
               cnt_next   = '0;
               fase_next  = 1'b0;
            end
            JOGANDO: begin
               cnt_next  = '0;
               fase_next = 1'b0;
               if (confirmar && (tiros < TIROS_MAX)) tiros_next = tiros + 7'd1;
               if (vitoria)      st_next = VITORIA;
               else if (derrota) st_next = DERROTA;
            end
            VITORIA, DERROTA: begin
               if (tick) begin
                  if (cnt == CNT_ULTIMO) begin
                     cnt_next  = '0;
                     fase_next = ~fase;
                  end else begin
                     cnt_next = cnt + CNT_W'(1);
                  end
               end
            end
            default: st_next = OCIOSO;
         endcase
      end

      // Display follows the state and phase being entered so outputs stay mutually consistent.
      unique case (st_next)
         OCIOSO:  matriz_next = '0;
         JOGANDO: matriz_next = acerto_v;
         VITORIA: matriz_next = fase_next ? '0 : mapa_v;
         DERROTA: matriz_next = fase_next ? acerto_v : (mapa_v | acerto_v);
         default: matriz_next = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st       <= OCIOSO;
         cnt      <= '0;
         fase     <= 1'b0;
         tiros    <= '0;
         matriz_v <= '0;
         fim      <= 1'b0;
      end else begin
         st       <= st_next;
         cnt      <= cnt_next;
         fase     <= fase_next;
         tiros    <= tiros_next;
         matriz_v <= matriz_next;
         fim      <= (st_next == VITORIA) || (st_next == DERROTA);
      end
   end

   assign estado  = st;
   assign matriz0 = matriz_v[6:0];
   assign matriz1 = matriz_v[13:7];
   assign matriz2 = matriz_v[20:14];
   assign matriz3 = matriz_v[27:21];
   assign matriz4 = matriz_v[34:28];

endmodule

// File: tb/tb_monitor_fim_de_jogo.sv
// Bench for monitor_fim_de_jogo: directed scenarios plus randomized play, checked against a
// behavioural game model that tracks state, shot count and total ticks since the game ended.
module tb_monitor_fim_de_jogo;

   localparam int P    = 4;
   localparam int MAXT = 99;

   logic       clock = 1'b0;
   logic       reset, enable, tick, confirmar;
   logic [6:0] mapa   [5];
   logic [6:0] acerto [5];
   logic [2:0] vida;
   logic [6:0] matriz [5];
   logic [1:0] estado;
   logic [6:0] tiros;
   logic       fim;
   logic [44:0] obs;

   int n_pass  = 0;
   int n_total = 0;

   // Model: 0 idle, 1 playing, 2 victory, 3 defeat.
   int         m_st    = 0;
   int         m_tiros = 0;
   int         m_ticks = 0;
   logic [6:0] m_mapa   [5];
   logic [6:0] m_acerto [5];

   monitor_fim_de_jogo #(.PISCA_TICKS(P), .MAX_TIROS(MAXT)) dut (
      .clock(clock), .reset(reset), .enable(enable), .tick(tick), .confirmar(confirmar),
      .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]), .mapa3(mapa[3]), .mapa4(mapa[4]),
      .acerto0(acerto[0]), .acerto1(acerto[1]), .acerto2(acerto[2]), .acerto3(acerto[3]),
      .acerto4(acerto[4]), .vida(vida),
      .matriz0(matriz[0]), .matriz1(matriz[1]), .matriz2(matriz[2]), .matriz3(matriz[3]),
      .matriz4(matriz[4]), .estado(estado), .tiros(tiros), .fim(fim)
   );

   always #5 clock = ~clock;

   assign obs = {estado, fim, tiros, matriz[4], matriz[3], matriz[2], matriz[1], matriz[0]};

   function automatic logic ganhou();
      logic algum = 1'b0;
      for (int k = 0; k < 5; k++)
         for (int n = 0; n < 7; n++) begin
            if (mapa[k][n]) algum = 1'b1;
            if (mapa[k][n] && !acerto[k][n]) return 1'b0;
         end
      return algum;
   endfunction

   function automatic logic [44:0] esperado();
      logic [34:0] mz;
      logic [6:0]  col;
      logic        fase;
      fase = ((m_ticks / P) % 2) == 1;
      for (int k = 0; k < 5; k++) begin
         case (m_st)
            1:       col = m_acerto[k];
            2:       col = fase ? 7'd0 : m_mapa[k];
            3:       col = fase ? m_acerto[k] : (m_mapa[k] | m_acerto[k]);
            default: col = 7'd0;
         endcase
         mz[k*7 +: 7] = col;
      end
      return {2'(m_st), (m_st >= 2) ? 1'b1 : 1'b0, 7'(m_tiros), mz};
   endfunction

   // Advance the model with the inputs present at the edge, then clock the DUT.
   task automatic passo();
      if (reset) begin
         m_st = 0; m_tiros = 0; m_ticks = 0;
      end else if (!enable) begin
         m_st = 0;
      end else begin
         case (m_st)
            0: begin m_st = 1; m_tiros = 0; m_ticks = 0; end
            1: begin
               if (confirmar && m_tiros < MAXT) m_tiros++;
               if (ganhou())         m_st = 2;
               else if (vida == 3'd0) m_st = 3;
            end
            default: if (tick) m_ticks++;
         endcase
      end
      m_mapa   = mapa;
      m_acerto = acerto;
      @(posedge clock);
      #1;
   endtask

   task automatic limpa();
      reset = 1'b0; enable = 1'b0; tick = 1'b0; confirmar = 1'b0; vida = 3'd3;
      for (int k = 0; k < 5; k++) begin
         mapa[k] = 7'd0; acerto[k] = 7'd0;
      end
   endtask

   task automatic reinicia();
      limpa();
      reset = 1'b1;
      passo();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      limpa();
      reset = 1'b1; enable = 1'b1; mapa[0] = 7'h7f;
      passo();
      passo();
      n_total++;
      if (obs !== 45'd0) $display("FAIL reset: got %h want 0", obs);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_vitoria();
      reinicia();
      enable = 1'b1; mapa[0] = 7'b0000111; vida = 3'd3;
      passo();
      n_total++;
      if (estado !== 2'b01 || matriz[0] !== 7'd0 || fim !== 1'b0)
         $display("FAIL vit_jogando: estado %b matriz0 %b fim %b want 01 0 0", estado, matriz[0], fim);
      else n_pass++;
      acerto[0] = 7'b0000111;
      passo();
      n_total++;
      if (estado !== 2'b10 || fim !== 1'b1 || matriz[0] !== 7'b0000111)
         $display("FAIL vit_entrada: estado %b fim %b matriz0 %b want 10 1 0000111",
                  estado, fim, matriz[0]);
      else n_pass++;
      for (int c = 0; c < 60; c++) begin
         tick = (c % 3 == 0);
         passo();
         n_total++;
         if (obs !== esperado()) $display("FAIL vit_pisca c=%0d: got %h want %h", c, obs, esperado());
         else n_pass++;
      end
      tick = 1'b0;
      n_total++;
      // 20 ticks delivered: phase toggled five times, so odd phase shows blank.
      if (matriz[0] !== 7'd0) $display("FAIL vit_fase_final: got %b want 0000000", matriz[0]);
      else n_pass++;
   endtask

   task automatic test_derrota();
      reinicia();
      enable = 1'b1; mapa[0] = 7'b0000111; acerto[0] = 7'b0000001; vida = 3'd2;
      passo();
      passo();
      vida = 3'd0;
      passo();
      n_total++;
      if (estado !== 2'b11 || matriz[0] !== 7'b0000111)
         $display("FAIL derrota_fase0: estado %b matriz0 %b want 11 0000111", estado, matriz[0]);
      else n_pass++;
      for (int c = 0; c < P; c++) begin
         tick = 1'b1;
         passo();
         tick = 1'b0;
         passo();
      end
      n_total++;
      if (matriz[0] !== 7'b0000001)
         $display("FAIL derrota_fase1: got %b want 0000001", matriz[0]);
      else n_pass++;
      n_total++;
      if (obs !== esperado()) $display("FAIL derrota_modelo: got %h want %h", obs, esperado());
      else n_pass++;
   endtask

   task automatic test_empate();
      reinicia();
      enable = 1'b1; mapa[2] = 7'b1010000; vida = 3'd1;
      passo();
      acerto[2] = 7'b1110000; vida = 3'd0;
      passo();
      n_total++;
      if (estado !== 2'b10) $display("FAIL empate: estado %b want 10", estado);
      else n_pass++;
   endtask

   task automatic test_tiros();
      reinicia();
      enable = 1'b1; mapa[0] = 7'b0000111; vida = 3'd3;
      passo();
      for (int i = 0; i < 105; i++) begin
         confirmar = 1'b1;
         passo();
         confirmar = 1'b0;
         passo();
      end
      n_total++;
      if (tiros !== 7'd99) $display("FAIL tiros_sat: got %0d want 99", tiros);
      else n_pass++;
      confirmar = 1'b1;
      passo();
      confirmar = 1'b0;
      n_total++;
      if (tiros !== 7'd99) $display("FAIL tiros_extra: got %0d want 99", tiros);
      else n_pass++;
      acerto[0] = 7'b0000111;
      passo();
      confirmar = 1'b1;
      passo();
      confirmar = 1'b0;
      n_total++;
      if (tiros !== 7'd99 || estado !== 2'b10)
         $display("FAIL tiros_vitoria: tiros %0d estado %b want 99 10", tiros, estado);
      else n_pass++;
      // A shot on the edge that enters a terminal state still counts.
      reinicia();
      enable = 1'b1; mapa[1] = 7'b0000010; vida = 3'd3;
      passo();
      acerto[1] = 7'b0000010; confirmar = 1'b1;
      passo();
      confirmar = 1'b0;
      n_total++;
      if (tiros !== 7'd1 || estado !== 2'b10)
         $display("FAIL tiros_transicao: tiros %0d estado %b want 1 10", tiros, estado);
      else n_pass++;
      // Falling enable with a shot: idle, shot dropped, count kept.
      enable = 1'b0; confirmar = 1'b1;
      passo();
      confirmar = 1'b0;
      n_total++;
      if (tiros !== 7'd1 || estado !== 2'b00 || matriz[1] !== 7'd0)
         $display("FAIL tiros_enable: tiros %0d estado %b m1 %b want 1 00 0", tiros, estado, matriz[1]);
      else n_pass++;
   endtask

   task automatic test_reset_meio();
      reinicia();
      enable = 1'b1; mapa[3] = 7'b0110000; acerto[3] = 7'b0010000; vida = 3'd1;
      passo();
      confirmar = 1'b1;
      passo();
      confirmar = 1'b0; vida = 3'd0;
      passo();
      tick = 1'b1;
      for (int i = 0; i < 6; i++) passo();
      tick = 1'b0;
      reset = 1'b1;
      passo();
      reset = 1'b0;
      n_total++;
      if (obs !== 45'd0) $display("FAIL reset_meio: got %h want 0", obs);
      else n_pass++;
      limpa();
      enable = 1'b1; vida = 3'd3;
      passo();
      n_total++;
      if (estado !== 2'b01) $display("FAIL reentrada: estado %b want 01", estado);
      else n_pass++;
      for (int i = 0; i < 5; i++) passo();
      n_total++;
      if (estado !== 2'b01) $display("FAIL mapa_vazio: estado %b want 01", estado);
      else n_pass++;
   endtask

   task automatic test_aleatorio();
      reinicia();
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 99) == 0);
         enable    = ($urandom_range(0, 39) != 0);
         tick      = ($urandom_range(0, 2) == 0);
         confirmar = ($urandom_range(0, 3) == 0);
         vida      = ($urandom_range(0, 29) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         if ($urandom_range(0, 49) == 0)
            for (int k = 0; k < 5; k++) mapa[k] = 7'($urandom) & 7'($urandom);
         if ($urandom_range(0, 5) == 0)
            for (int k = 0; k < 5; k++)
               acerto[k] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : (mapa[k] | 7'($urandom_range(0, 1)));
         passo();
         n_total++;
         if (obs !== esperado()) $display("FAIL aleatorio c=%0d: got %h want %h", c, obs, esperado());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_vitoria();
      test_derrota();
      test_empate();
      test_tiros();
      test_reset_meio();
      test_aleatorio();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
